// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : 2R/1W register file with registered reads, write->read bypass
//             and a per-register pending-write scoreboard for RAW detection.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_pend,
    output logic             rs2_pend,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    output logic [AW:0]      pend_cnt
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;
    logic [AW:0]      w_cnt_nxt;

    logic             w_wr_ok;
    logic             w_iss_ok;
    logic             w_rs1_ok;
    logic             w_rs2_ok;
    logic             w_rs1_byp;
    logic             w_rs2_byp;
    logic [WIDTH-1:0] w_rs1_val;
    logic [WIDTH-1:0] w_rs2_val;
    logic             w_rs1_pnd;
    logic             w_rs2_pnd;

    // Register 0 and out-of-range addresses are never valid targets or sources.
    assign w_wr_ok  = wr_en  && (wr_addr  != '0) && ({1'b0, wr_addr}  < c_depth);
    assign w_iss_ok = iss_en && (iss_addr != '0) && ({1'b0, iss_addr} < c_depth);
    assign w_rs1_ok = (rs1_addr != '0) && ({1'b0, rs1_addr} < c_depth);
    assign w_rs2_ok = (rs2_addr != '0) && ({1'b0, rs2_addr} < c_depth);

    assign w_rs1_byp = w_wr_ok && (wr_addr == rs1_addr);
    assign w_rs2_byp = w_wr_ok && (wr_addr == rs2_addr);

    assign w_rs1_val = !w_rs1_ok ? '0 : (w_rs1_byp ? wr_data : r_regs[rs1_addr]);
    assign w_rs2_val = !w_rs2_ok ? '0 : (w_rs2_byp ? wr_data : r_regs[rs2_addr]);

    // A same-cycle writeback satisfies the read; a same-cycle issue is younger.
    assign w_rs1_pnd = w_rs1_ok && r_pend[rs1_addr] && !w_rs1_byp;
    assign w_rs2_pnd = w_rs2_ok && r_pend[rs2_addr] && !w_rs2_byp;

    // Clear before set so a newer issue to the same address stays outstanding.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_ok) begin
            w_pend_nxt[wr_addr] = 1'b0;
        end
        if (w_iss_ok) begin
            w_pend_nxt[iss_addr] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_pend_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= '0;
            pend_cnt <= '0;
        end else begin
            r_pend   <= w_pend_nxt;
            pend_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_data <= '0;
            rs2_data <= '0;
            rs1_pend <= 1'b0;
            rs2_pend <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rs1_data <= w_rs1_val;
                rs2_data <= w_rs2_val;
                rs1_pend <= w_rs1_pnd;
                rs2_pend <= w_rs2_pnd;
            end
        end
    end

endmodule
`default_nettype wire
